// File: rtl/adau_seq.sv
// adau_seq - analog acquisition frame sequencer.
//
// On each frame trigger (sec) the sequencer emits SYNC_WORD on the output stream, then walks
// CHANNELS entries of the channel table. For each entry it:
//   1. reads the table word,
//   2. drives the mux with it and waits SETTLE_CLKS cycles,
//   3. requests one ADC conversion,
//   4. emits the captured sample on a valid/ready stream.
// A sec pulse that arrives while a frame is in flight is ignored, but it sets the sticky
// overrun flag.
//
// Optional feature, selected by the ADAU_PARK_EN macro:
//   defined   - the mux is switched to the park code (PARK_ADDR/PARK_ENA) in the capture cycle,
//               and PARK_CLKS cycles of PARK are inserted between channels.
//   undefined - after a capture the mux keeps the channel code until the next table fetch.
// In both builds IDLE and reset use the park code.
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   asynchronous, active-low
//   sec         in   frame trigger, one-cycle pulse
//   table_addr  out  channel-table read address (synchronous RAM, one cycle latency)
//   table_q     in   table word {ADDR, ENA}
//   ADDR, ENA   out  mux address / enable
//   adc_start   out  conversion request, a level held until adc_rdy
//   adc_rdy     in   one-cycle sample-ready pulse
//   adc_sample  in   ADC result, valid with adc_rdy
//   out_valid   out  stream word valid
//   out_ready   in   stream sink can accept
//   out_data    out  SYNC_WORD or a sample
//   out_sync    out  out_data holds the sync word
//   out_chan    out  table index of the sample (0 with sync)
//   frame_done  out  one-cycle pulse after the last channel is accepted
//   overrun     out  sticky: sec arrived while the sequencer was busy
module adau_seq #(
    parameter int unsigned          CHANNELS    = 64,
    parameter int unsigned          ADDR_W      = 4,
    parameter int unsigned          ENA_W       = 4,
    parameter int unsigned          SAMPLE_W    = 16,
    parameter int unsigned          SETTLE_CLKS = 1220,
    parameter int unsigned          PARK_CLKS   = 72,
    parameter logic [ADDR_W-1:0]    PARK_ADDR   = 4'hF,
    parameter logic [ENA_W-1:0]     PARK_ENA    = 4'h1,
    parameter logic [SAMPLE_W-1:0]  SYNC_WORD   = 16'hFF7F,
    localparam int unsigned         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sec,
    output logic [CH_W-1:0]           table_addr,
    input  logic [ADDR_W+ENA_W-1:0]   table_q,
    output logic [ADDR_W-1:0]         ADDR,
    output logic [ENA_W-1:0]          ENA,
    output logic                      adc_start,
    input  logic                      adc_rdy,
    input  logic [SAMPLE_W-1:0]       adc_sample,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SAMPLE_W-1:0]       out_data,
    output logic                      out_sync,
    output logic [CH_W-1:0]           out_chan,
    output logic                      frame_done,
    output logic                      overrun
);

    localparam int unsigned     CntW        = 16;
    localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CLKS - 1);
    localparam logic [CntW-1:0] ParkLast    = CntW'(PARK_CLKS - 1);
    localparam logic [CH_W-1:0] LastIdx     = CH_W'(CHANNELS - 1);

    // StPark exists in both builds; it is only reachable when ADAU_PARK_EN is defined.
    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StFetch1,
        StFetch2,
        StSettle,
        StConvert,
        StEmit,
        StPark
    } state_e;

    state_e                state_q, state_d;
    logic [CH_W-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ENA_W-1:0]      ena_q, ena_d;
    logic                  start_q, start_d;
    logic                  valid_q, valid_d;
    logic [SAMPLE_W-1:0]   data_q, data_d;
    logic                  sync_q, sync_d;
    logic [CH_W-1:0]       chan_q, chan_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic                  handshake;

    assign handshake = valid_q & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= PARK_ADDR;
            ena_q     <= PARK_ENA;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            sync_q    <= 1'b0;
            chan_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            ena_q     <= ena_d;
            start_q   <= start_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sync_q    <= sync_d;
            chan_q    <= chan_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        ena_d     = ena_q;
        start_d   = start_q;
        valid_d   = valid_q;
        data_d    = data_q;
        sync_d    = sync_q;
        chan_d    = chan_q;
        done_d    = 1'b0;
        // A trigger while busy is only recorded; it never restarts the frame.
        overrun_d = overrun_q | (sec & (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                addr_d = PARK_ADDR;
                ena_d  = PARK_ENA;
                if (sec) begin
                    valid_d = 1'b1;
                    sync_d  = 1'b1;
                    data_d  = SYNC_WORD;
                    chan_d  = '0;
                    state_d = StSync;
                end
            end

            StSync: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    sync_d  = 1'b0;
                    idx_d   = '0;
                    state_d = StFetch1;
                end
            end

            // table_addr follows idx_q; the RAM word is valid one cycle later.
            StFetch1: begin
                state_d = StFetch2;
            end

            StFetch2: begin
                addr_d  = table_q[ADDR_W+ENA_W-1:ENA_W];
                ena_d   = table_q[ENA_W-1:0];
                cnt_d   = '0;
                state_d = StSettle;
            end

            StSettle: begin
                if (cnt_q == SettleLast) begin
                    start_d = 1'b1;
                    state_d = StConvert;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StConvert: begin
                if (adc_rdy) begin
                    data_d  = adc_sample;
                    chan_d  = idx_q;
                    start_d = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StEmit;
`ifdef ADAU_PARK_EN
                    // Ground the ADC input as soon as the sample is taken.
                    addr_d  = PARK_ADDR;
                    ena_d   = PARK_ENA;
`endif
                end
            end

            StEmit: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (idx_q == LastIdx) begin
                        done_d  = 1'b1;
                        addr_d  = PARK_ADDR;
                        ena_d   = PARK_ENA;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + CH_W'(1);
`ifdef ADAU_PARK_EN
                        state_d = StPark;
`else
                        state_d = StFetch1;
`endif
                    end
                end
            end

            StPark: begin
                addr_d = PARK_ADDR;
                ena_d  = PARK_ENA;
                if (cnt_q == ParkLast) begin
                    state_d = StFetch1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign table_addr = idx_q;
    assign ADDR       = addr_q;
    assign ENA        = ena_q;
    assign adc_start  = start_q;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_sync   = sync_q;
    assign out_chan   = chan_q;
    assign frame_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_adau_seq.sv
// Directed bench for adau_seq with CHANNELS=4, SETTLE_CLKS=10 and PARK_CLKS=8.
// A registered table RAM and an ADC model are included. The ADC model answers 20 cycles after
// adc_start, with the sample {8'h5A, ADDR, ENA}.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_adau_seq;

    localparam int unsigned NCH     = 4;
    localparam int unsigned SETTLE  = 10;
    localparam int unsigned PARKN   = 8;
    localparam int unsigned ADC_LAT = 20;
    localparam logic [7:0]  PARK    = 8'hF1;

    typedef struct packed {
        logic [7:0]  code;       // table word {ADDR, ENA}
        int          stall;      // cycles out_ready is held low in EMIT
        bit          sec_pulse;  // sec pulse while settling
        bit          spur;       // spurious adc_rdy while settling
        logic [15:0] exp_data;
        int          exp_chan;
    } vec_t;

    vec_t vec [0:NCH-1];

    logic        clock;
    logic        reset;
    logic        sec;
    logic [1:0]  table_addr;
    logic [7:0]  table_q;
    logic [3:0]  ADDR;
    logic [3:0]  ENA;
    logic        adc_start;
    logic        adc_rdy;
    logic [15:0] adc_sample;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sync;
    logic [1:0]  out_chan;
    logic        frame_done;
    logic        overrun;

    logic        model_rdy;
    logic [15:0] model_sample;
    logic        spur_rdy;

    int checks   = 0;
    int failures = 0;
    bit exp_ovr  = 1'b0;

    adau_seq #(
        .CHANNELS    (NCH),
        .SETTLE_CLKS (SETTLE),
        .PARK_CLKS   (PARKN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sec        (sec),
        .table_addr (table_addr),
        .table_q    (table_q),
        .ADDR       (ADDR),
        .ENA        (ENA),
        .adc_start  (adc_start),
        .adc_rdy    (adc_rdy),
        .adc_sample (adc_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sync   (out_sync),
        .out_chan   (out_chan),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Channel-table RAM, one cycle read latency.
    always @(posedge clock) table_q <= vec[table_addr].code;

    assign adc_rdy    = model_rdy | spur_rdy;
    assign adc_sample = spur_rdy ? 16'hDEAD : model_sample;

    // ADC model: ready pulse sampled by the DUT ADC_LAT edges after adc_start rose.
    initial begin
        int cnt;
        cnt = 0;
        model_rdy = 1'b0;
        model_sample = 16'h0;
        forever begin
            @(negedge clock);
            model_rdy = 1'b0;
            if (adc_start) begin
                if (cnt == ADC_LAT - 1) begin
                    model_rdy    = 1'b1;
                    model_sample = {8'h5A, ADDR, ENA};
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fires sec in IDLE, checks the sync word and completes its handshake after 'stall' cycles.
    task automatic do_sync(input int stall);
        int bad;
        sec = 1'b1;
        tick();
        sec = 1'b0;
        check("sync_valid", out_valid, 1);
        check("sync_flag", out_sync, 1);
        check("sync_data", out_data, 16'hFF7F);
        check("sync_chan", out_chan, 0);
        check("sync_overrun", overrun, exp_ovr);
        bad = 0;
        out_ready = (stall == 0);
        for (int k = 0; k < stall; k++) begin
            tick();
            if (!out_valid || !out_sync || out_data !== 16'hFF7F || adc_start) bad++;
        end
        out_ready = 1'b1;
        check("sync_stall_hold", bad, 0);
        tick();
        check("sync_done_valid", out_valid, 0);
    endtask

    // Runs one table entry. It starts on the falling edge just after the previous handshake and
    // ends on the falling edge just after this entry's handshake.
    task automatic run_chan(input int i, input bit use_sec, input bit end_sec);
        int         n;
        int         bad;
        int         gap_exp;
        logic [7:0] hold;
        logic [7:0] mux_exp;
        if (i == 0) begin
            hold    = PARK;
            gap_exp = 2;
        end else begin
`ifdef ADAU_PARK_EN
            hold    = PARK;
            gap_exp = 2 + PARKN;
`else
            hold    = vec[i-1].code;
            gap_exp = 2;
`endif
        end
`ifdef ADAU_PARK_EN
        mux_exp = PARK;
`else
        mux_exp = vec[i].code;
`endif

        n = 0;
        bad = 0;
        while (n < 200) begin
            tick();
            n++;
            if ({ADDR, ENA} == vec[i].code) break;
            if ({ADDR, ENA} != hold) bad++;
        end
        check("mux_gap", n, gap_exp);
        check("mux_hold", bad, 0);
        check("table_addr", table_addr, i);

        n = 0;
        sec = use_sec & vec[i].sec_pulse;
        spur_rdy = vec[i].spur;
        if (use_sec && vec[i].sec_pulse) exp_ovr = 1'b1;
        while (!adc_start && n < 100) begin
            tick();
            sec = 1'b0;
            spur_rdy = 1'b0;
            n++;
        end
        sec = 1'b0;
        spur_rdy = 1'b0;
        check("settle_cycles", n, SETTLE);
        check("overrun", overrun, exp_ovr);

        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("conv_cycles", n, ADC_LAT);
        check("emit_data", out_data, vec[i].exp_data);
        check("emit_chan", out_chan, vec[i].exp_chan);
        check("emit_sync", out_sync, 0);
        check("emit_start_low", adc_start, 0);
        check("emit_mux", {ADDR, ENA}, mux_exp);

        bad = 0;
        out_ready = (vec[i].stall == 0);
        for (int k = 0; k < vec[i].stall; k++) begin
            tick();
            if (!out_valid || out_data !== vec[i].exp_data || out_chan !== 2'(vec[i].exp_chan)
                || adc_start) bad++;
        end
        out_ready = 1'b1;
        check("stall_hold", bad, 0);

        sec = end_sec;
        if (end_sec) exp_ovr = 1'b1;
        tick();
        sec = 1'b0;
        check("frame_done", frame_done, (i == NCH - 1) ? 1 : 0);
        check("post_valid", out_valid, 0);
    endtask

    task automatic end_frame();
        tick();
        check("done_pulse_end", frame_done, 0);
        check("idle_valid", out_valid, 0);
        check("idle_mux", {ADDR, ENA}, PARK);
        check("idle_overrun", overrun, exp_ovr);
    endtask

    initial begin
        int n;
        vec[0] = '{code: 8'h31, stall: 0,  sec_pulse: 1'b0, spur: 1'b0,
                   exp_data: 16'h5A31, exp_chan: 0};
        vec[1] = '{code: 8'h52, stall: 50, sec_pulse: 1'b0, spur: 1'b1,
                   exp_data: 16'h5A52, exp_chan: 1};
        vec[2] = '{code: 8'h74, stall: 0,  sec_pulse: 1'b1, spur: 1'b0,
                   exp_data: 16'h5A74, exp_chan: 2};
        vec[3] = '{code: 8'h98, stall: 3,  sec_pulse: 1'b0, spur: 1'b0,
                   exp_data: 16'h5A98, exp_chan: 3};

        reset = 1'b0;
        sec = 1'b0;
        out_ready = 1'b1;
        spur_rdy = 1'b0;
        tick();
        check("rst_addr", ADDR, 4'hF);
        check("rst_ena", ENA, 4'h1);
        check("rst_start", adc_start, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sync", out_sync, 0);
        check("rst_chan", out_chan, 0);
        check("rst_table_addr", table_addr, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;
        repeat (3) tick();

        // Frame 1: backpressure on chan 1, overrun sec while chan 2 settles.
        do_sync(0);
        for (int i = 0; i < NCH; i++) run_chan(i, 1'b1, 1'b0);
        end_frame();
        repeat (5) tick();

        // Frame 2: stalled sync, then reset while chan 1 is converting.
        do_sync(3);
        run_chan(0, 1'b1, 1'b0);
        n = 0;
        while (!adc_start && n < 100) begin
            tick();
            n++;
        end
        check("f2_start_seen", adc_start, 1);
        repeat (5) tick();
        check("f2_overrun_before_reset", overrun, 1);
        reset = 1'b0;
        exp_ovr = 1'b0;
        #1;
        check("mid_rst_start", adc_start, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_mux", {ADDR, ENA}, PARK);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_table_addr", table_addr, 0);
        check("mid_rst_data", out_data, 0);
        tick();
        reset = 1'b1;
        repeat (3) tick();

        // Frame 3: clean frame; sec lands on the final handshake cycle.
        do_sync(0);
        for (int i = 0; i < NCH; i++) run_chan(i, 1'b0, i == NCH - 1);
        end_frame();
        repeat (2) tick();

        // The sequencer must be back in IDLE and accept a new trigger.
        do_sync(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
